sync_fifo_ram: RTL and testbench
================================

Name: sync_fifo_ram

Overview:
Parametrised synchronous FIFO built on an internal dual-address RAM with wrapping read/write pointer counters. It generalises our single-read-port RAM and up-counter primitives into one buffered block with flow-control flags. Used between producer/consumer stages in the same clock domain, such as sample capture to a display/UART path.

Parameters:
DATA_WIDTH, 16, width of each stored word.
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 16).
ALMOST_FULL_LEVEL, 12, count at or above which oAlmostFull asserts; legal range 1..DEPTH.

Ports:
Clock  input  1  single clock; all state changes on posedge.
Reset  input  1  synchronous, active-low reset, sampled on posedge Clock.
iWriteEnable  input  1  write request.
iDataIn  input  DATA_WIDTH  write data.
iReadEnable  input  1  read request.
oDataOut  output  DATA_WIDTH  read data, registered.
oDataValid  output  1  oDataOut updated by a read this cycle.
oEmpty  output  1  no stored words.
oFull  output  1  DEPTH words stored.
oAlmostFull  output  1  count >= ALMOST_FULL_LEVEL.
oCount  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset low at posedge: wr_ptr=0, rd_ptr=0, oCount=0, oEmpty=1, oFull=0, oAlmostFull=0, oDataValid=0, oDataOut=0. RAM contents are not cleared; they are unreachable until rewritten. Reset overrides all requests in the same cycle.
- Write accepted iff iWriteEnable=1 and oFull=0. On accept: RAM[wr_ptr]<=iDataIn and wr_ptr<=wr_ptr+1.
- Read accepted iff iReadEnable=1 and oEmpty=0. On accept: oDataOut<=RAM[rd_ptr], rd_ptr<=rd_ptr+1, and oDataValid<=1 for exactly the next cycle.
- Otherwise oDataValid<=0 and oDataOut holds its last value.
- Read latency: data appears 1 cycle after the accepting edge.
- Pointers wrap from DEPTH-1 to 0 with natural ADDR_WIDTH-bit rollover. No explicit compare is used.
- oCount update: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are registered and derived from the next oCount value:
  - oEmpty = (count==0)
  - oFull = (count==DEPTH)
  - oAlmostFull = (count>=ALMOST_FULL_LEVEL)
- Simultaneous read and write:
  - When 0<count<DEPTH, both are accepted and count is unchanged.
  - When empty, only the write is accepted. No fall-through, no read-during-write hazard.
  - When full, only the read is accepted. The write is dropped.
- Rejected requests (write when full, read when empty) have no effect on any state.

Optional Feature:
SYNC_FIFO_ERR_FLAGS_EN:
- When defined, adds two outputs, oOverflow and oUnderflow (1 bit each, reset 0).
  - oOverflow sets sticky on a rejected write (iWriteEnable=1 while oFull=1).
  - oUnderflow sets sticky on a rejected read (iReadEnable=1 while oEmpty=1).
  - Both clear only on Reset low.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Hold Reset=0 for 2 cycles with both enables high -> oCount=0, oEmpty=1, oFull=0, oDataValid=0, oDataOut=0 throughout.
2. Write 0x0000..0x000F on 16 consecutive cycles, then write 0xDEAD:
   - oAlmostFull rises after the 12th write; oFull rises after the 16th; oCount=16.
   - 0xDEAD is dropped and oCount stays 16.
   - With the macro, oOverflow=1.
3. From full, assert iReadEnable for 17 cycles:
   - oDataOut = 0x0000..0x000F, each one cycle after its accepting edge, with oDataValid high for 16 cycles.
   - oEmpty=1 after the last read; the 17th read is ignored and oDataOut holds 0x000F.
   - With the macro, oUnderflow=1.
4. Preload 5 words, then assert read and write together for 20 cycles with data 0x0100+n:
   - oCount stays 5 and pointers wrap past 15.
   - Read order: the 5 preloaded words, then 0x0100, 0x0101, ... in order.
5. When empty, assert read and write together with 0xBEEF -> write accepted, oCount=1, oDataValid=0; the next read returns 0xBEEF.
6. With 7 words stored, drive Reset=0 for one cycle while writing -> next cycle oCount=0, oEmpty=1; a subsequent write of 0x1234 followed by a read returns 0x1234.

Source files
------------

// File: rtl/sync_fifo_ram_if.sv
// Producer/consumer handshake bundle for sync_fifo_ram.
// Defining SYNC_FIFO_ERR_FLAGS_EN adds the sticky oOverflow/oUnderflow signals.
interface sync_fifo_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  iWriteEnable;
    logic [DATA_WIDTH-1:0] iDataIn;
    logic                  iReadEnable;
    logic [DATA_WIDTH-1:0] oDataOut;
    logic                  oDataValid;
    logic                  oEmpty;
    logic                  oFull;
    logic                  oAlmostFull;
    logic [ADDR_WIDTH:0]   oCount;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  oOverflow;
    logic                  oUnderflow;
`endif

    modport master (
        output iWriteEnable, iDataIn, iReadEnable,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        input  oOverflow, oUnderflow,
`endif
        input  oDataOut, oDataValid, oEmpty, oFull, oAlmostFull, oCount
    );

    modport slave (
        input  iWriteEnable, iDataIn, iReadEnable,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        output oOverflow, oUnderflow,
`endif
        output oDataOut, oDataValid, oEmpty, oFull, oAlmostFull, oCount
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over a dual-address RAM with registered occupancy flags.
// Defining SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifo_ram #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 4,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic Clock,
    input  logic Reset,
    sync_fifo_ram_if.slave bus
);
    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q, empty_q, full_q, afull_q;
    logic                  wr_acc, rd_acc;

    // Reset gates acceptance so a request during reset never touches RAM or pointers.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_acc  = Reset & bus.iWriteEnable & ~full_q;
        rd_acc  = Reset & bus.iReadEnable  & ~empty_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; stale words are unreachable until rewritten.
    always_ff @(posedge Clock) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.iDataIn;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                dout_q   <= mem_q[rd_ptr_q];
            end
            valid_q <= rd_acc;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_CNT);
            afull_q <= (count_d >= AF_CNT);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (bus.iWriteEnable & full_q);
            underflow_q <= underflow_q | (bus.iReadEnable  & empty_q);
        end
    end

    assign bus.oOverflow  = overflow_q;
    assign bus.oUnderflow = underflow_q;
`endif

    assign bus.oDataOut    = dout_q;
    assign bus.oDataValid  = valid_q;
    assign bus.oEmpty      = empty_q;
    assign bus.oFull       = full_q;
    assign bus.oAlmostFull = afull_q;
    assign bus.oCount      = count_q;
endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed bench for sync_fifo_ram: a scoreboard queue holds expected read data,
// a negedge monitor pops it whenever oDataValid is high.
module tb_sync_fifo_ram;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] exp_q [$];

    sync_fifo_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    sync_fifo_ram #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .ALMOST_FULL_LEVEL(12)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every valid read result must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.oDataValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus.oDataOut), 32'hFFFF_FFFF);
            end else begin
                check("read_data", 32'(bus.oDataOut), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drive one cycle of stimulus, starting and ending on a negedge.
    task automatic step(input logic we, input logic [15:0] din, input logic re);
        bus.iWriteEnable = we;
        bus.iDataIn      = din;
        bus.iReadEnable  = re;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic emp,
                               input logic ful, input logic af);
        check({tag, "_count"}, 32'(bus.oCount), 32'(cnt));
        check({tag, "_empty"}, 32'(bus.oEmpty), 32'(emp));
        check({tag, "_full"},  32'(bus.oFull),  32'(ful));
        check({tag, "_afull"}, 32'(bus.oAlmostFull), 32'(af));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.iWriteEnable = 1'b1;
        bus.iDataIn      = 16'hAAAA;
        bus.iReadEnable  = 1'b1;

        // 1: reset held with both enables high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_flags("rst", 0, 1'b1, 1'b0, 1'b0);
            check("rst_valid", 32'(bus.oDataValid), 32'd0);
            check("rst_dout",  32'(bus.oDataOut),   32'd0);
        end
        rst_n = 1'b1;

        // 2: fill to full, then a dropped write
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 16'(k - 1), 1'b0);
            check_flags("fill", k, 1'b0, k == 16, k >= 12);
        end
        step(1'b1, 16'hDEAD, 1'b0);
        check_flags("ovf_write", 16, 1'b0, 1'b1, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow", 32'(bus.oOverflow), 32'd1);
        check("no_underflow", 32'(bus.oUnderflow), 32'd0);
`endif

        // 3: drain 16 words, 17th read rejected
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(16'(i));
            step(1'b0, 16'h0, 1'b1);
            if (i < 16) check_flags("drain", 15 - i, i == 15, 1'b0, (15 - i) >= 12);
        end
        check_flags("udf_read", 0, 1'b1, 1'b0, 1'b0);
        check("udf_valid", 32'(bus.oDataValid), 32'd0);
        check("udf_hold",  32'(bus.oDataOut),   32'h000F);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("underflow", 32'(bus.oUnderflow), 32'd1);
`endif

        // 4: preload 5, then 20 cycles of simultaneous read/write across the wrap
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0);
        check_flags("preload", 5, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            exp_q.push_back(n < 5 ? 16'h0050 + 16'(n) : 16'h0100 + 16'(n - 5));
            step(1'b1, 16'h0100 + 16'(n), 1'b1);
            check("rw_count", 32'(bus.oCount), 32'd5);
        end
        for (int n = 15; n < 20; n++) begin
            exp_q.push_back(16'h0100 + 16'(n));
            step(1'b0, 16'h0, 1'b1);
        end
        check_flags("rw_drained", 0, 1'b1, 1'b0, 1'b0);

        // 5: simultaneous read/write while empty: only the write lands
        step(1'b1, 16'hBEEF, 1'b1);
        check_flags("empty_rw", 1, 1'b0, 1'b0, 1'b0);
        check("empty_rw_valid", 32'(bus.oDataValid), 32'd0);
        exp_q.push_back(16'hBEEF);
        step(1'b0, 16'h0, 1'b1);
        check("beef_count", 32'(bus.oCount), 32'd0);

        // 6: reset with 7 words stored while writing
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0700 + 16'(i), 1'b0);
        check("pre_rst_count", 32'(bus.oCount), 32'd7);
        rst_n = 1'b0;
        step(1'b1, 16'h5555, 1'b0);
        rst_n = 1'b1;
        check_flags("mid_rst", 0, 1'b1, 1'b0, 1'b0);
        check("mid_rst_valid", 32'(bus.oDataValid), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("rst_clr_underflow", 32'(bus.oUnderflow), 32'd0);
`endif
        step(1'b1, 16'h1234, 1'b0);
        exp_q.push_back(16'h1234);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
